// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe
//
// ID/EX pipeline register for the 5-stage RV32I pipeline. It sits directly
// downstream of the instruction decoder. Each cycle it captures the decoder
// controls and the ID-stage operands. It also detects load-use hazards and
// inserts bubbles, and it kills the ID instruction on a branch/jump redirect
// coming from EX.
//
// Update priority at each rising edge (rstn == 1):
//   hold  -> every ex_* field keeps its value (flush and load-use are ignored)
//   flush -> bubble
//   lu    -> bubble; ID is frozen through stall, so the instruction re-enters
//   else  -> all id_* fields are loaded, ex_valid = id_valid
// A bubble drives every ex_* field to zero, including the datapath fields.
//
// Optional build macro: ID_EX_PERF_CNT_EN
//   When it is defined, the module has two free-running wrap-around counters
//   and the ports perf_lu_cnt and perf_flush_cnt. The counters count the
//   edges on which a load-use bubble or a flush bubble was actually applied.
//
// Ports
//   clk, rstn         clock, synchronous active-low reset
//   hold              global freeze; all state held
//   flush             EX redirect; kills the instruction in ID
//   id_*              decoder controls, operands and register addresses
//   ex_*              registered copies of every id_* field
//   stall             combinational; freezes PC and IF/ID
//   perf_*            bubble counters (ID_EX_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module id_ex_pipe #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            hold,
    input  logic            flush,

    input  logic            id_valid,
    input  logic            id_RegWrite,
    input  logic            id_MemWrite,
    input  logic            id_MemRead,
    input  logic            id_ALUSrc,
    input  logic [4:0]      id_ALUOp,
    input  logic [2:0]      id_NPCOp,
    input  logic [1:0]      id_WDSel,
    input  logic [2:0]      id_DMType,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,

    output logic            ex_valid,
    output logic            ex_RegWrite,
    output logic            ex_MemWrite,
    output logic            ex_MemRead,
    output logic            ex_ALUSrc,
    output logic [4:0]      ex_ALUOp,
    output logic [2:0]      ex_NPCOp,
    output logic [1:0]      ex_WDSel,
    output logic [2:0]      ex_DMType,
    output logic            ex_use_rs1,
    output logic            ex_use_rs2,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,

    output logic            stall
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]     perf_lu_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    typedef struct packed {
        logic            valid;
        logic            RegWrite;
        logic            MemWrite;
        logic            MemRead;
        logic            ALUSrc;
        logic [4:0]      ALUOp;
        logic [2:0]      NPCOp;
        logic [1:0]      WDSel;
        logic [2:0]      DMType;
        logic            use_rs1;
        logic            use_rs2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
    } stage_t;

    stage_t id_s;
    stage_t stage_d;
    stage_t stage_q;
    logic   lu;
    logic   rs1_hit;
    logic   rs2_hit;

    // Gather the decoder-side fields into one record.
    always_comb begin
        id_s          = '0;
        id_s.valid    = id_valid;
        id_s.RegWrite = id_RegWrite;
        id_s.MemWrite = id_MemWrite;
        id_s.MemRead  = id_MemRead;
        id_s.ALUSrc   = id_ALUSrc;
        id_s.ALUOp    = id_ALUOp;
        id_s.NPCOp    = id_NPCOp;
        id_s.WDSel    = id_WDSel;
        id_s.DMType   = id_DMType;
        id_s.use_rs1  = id_use_rs1;
        id_s.use_rs2  = id_use_rs2;
        id_s.pc       = id_pc;
        id_s.rd1      = id_rd1;
        id_s.rd2      = id_rd2;
        id_s.imm      = id_imm;
        id_s.rs1      = id_rs1;
        id_s.rs2      = id_rs2;
        id_s.rd       = id_rd;
    end

    // Load-use check. A load that writes x0 never stalls. Once the bubble
    // is in EX, ex_MemRead is 0, so a load-use pair costs exactly one
    // bubble.
    assign rs1_hit = id_use_rs1 && (id_rs1 == stage_q.rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == stage_q.rd);
    assign lu      = stage_q.valid && stage_q.MemRead && (stage_q.rd != '0)
                     && id_valid && (rs1_hit || rs2_hit);

    // A flush kills the ID instruction anyway, so there is no point in
    // freezing it.
    assign stall = lu && !flush;

    always_comb begin
        stage_d = stage_q;
        if (!hold) begin
            if (flush || lu) begin
                stage_d = '0;
            end else begin
                stage_d = id_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign ex_valid    = stage_q.valid;
    assign ex_RegWrite = stage_q.RegWrite;
    assign ex_MemWrite = stage_q.MemWrite;
    assign ex_MemRead  = stage_q.MemRead;
    assign ex_ALUSrc   = stage_q.ALUSrc;
    assign ex_ALUOp    = stage_q.ALUOp;
    assign ex_NPCOp    = stage_q.NPCOp;
    assign ex_WDSel    = stage_q.WDSel;
    assign ex_DMType   = stage_q.DMType;
    assign ex_use_rs1  = stage_q.use_rs1;
    assign ex_use_rs2  = stage_q.use_rs2;
    assign ex_pc       = stage_q.pc;
    assign ex_rd1      = stage_q.rd1;
    assign ex_rd2      = stage_q.rd2;
    assign ex_imm      = stage_q.imm;
    assign ex_rs1      = stage_q.rs1;
    assign ex_rs2      = stage_q.rs2;
    assign ex_rd       = stage_q.rd;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] lu_cnt_q;
    logic [31:0] lu_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    // Each bubble is charged to the cause that won the priority. When flush
    // and load-use coincide, only flush is counted. Both counters wrap
    // naturally.
    always_comb begin
        lu_cnt_d    = lu_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!hold) begin
            if (flush) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end else if (lu) begin
                lu_cnt_d = lu_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lu_cnt_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            lu_cnt_q    <= lu_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_lu_cnt    = lu_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

    localparam int XLEN = 32;
    localparam int RA_W = 5;
    localparam int VW   = 163;

    logic            clk = 1'b0;
    logic            rstn, hold, flush;
    logic            id_valid, id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc;
    logic [4:0]      id_ALUOp;
    logic [2:0]      id_NPCOp;
    logic [1:0]      id_WDSel;
    logic [2:0]      id_DMType;
    logic            id_use_rs1, id_use_rs2;
    logic [XLEN-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic            ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc;
    logic [4:0]      ex_ALUOp;
    logic [2:0]      ex_NPCOp;
    logic [1:0]      ex_WDSel;
    logic [2:0]      ex_DMType;
    logic            ex_use_rs1, ex_use_rs2;
    logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic            stall;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]     perf_lu_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_pipe #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rstn(rstn), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite),
        .id_MemRead(id_MemRead), .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
        .id_NPCOp(id_NPCOp), .id_WDSel(id_WDSel), .id_DMType(id_DMType),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_pc(id_pc),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
        .ex_MemRead(ex_MemRead), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
        .ex_NPCOp(ex_NPCOp), .ex_WDSel(ex_WDSel), .ex_DMType(ex_DMType),
        .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2), .ex_pc(ex_pc),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .stall(stall)
`ifdef ID_EX_PERF_CNT_EN
        , .perf_lu_cnt(perf_lu_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    logic [VW-1:0] ex_vec;
    assign ex_vec = {ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc,
                     ex_ALUOp, ex_NPCOp, ex_WDSel, ex_DMType, ex_use_rs1, ex_use_rs2,
                     ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd};

    typedef struct {
        logic       rstn;
        logic       hold;
        logic       flush;
        logic       valid;
        logic       memread;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [7:0] tag;
        logic       chk_stall;
        logic       exp_stall;
        int         exp_src;   // -1: zero (bubble/reset), else row index whose id_* fields are expected
    } row_t;

    int checks = 0;
    int errors = 0;
    row_t rows[25];

    function automatic row_t mk(logic r, logic h, logic f, logic v, logic mr,
                                int rd, int rs1, int rs2, logic u1, logic u2,
                                int tag, logic cs, logic es, int src);
        row_t x;
        x.rstn = r; x.hold = h; x.flush = f; x.valid = v; x.memread = mr;
        x.rd = rd[4:0]; x.rs1 = rs1[4:0]; x.rs2 = rs2[4:0];
        x.u1 = u1; x.u2 = u2; x.tag = tag[7:0];
        x.chk_stall = cs; x.exp_stall = es; x.exp_src = src;
        return x;
    endfunction

    // The remaining id_* fields are derived from the tag, so each row carries a distinct pattern.
    function automatic logic [VW-1:0] row_vec(row_t r);
        logic [7:0] t;
        t = r.tag;
        return {r.valid, t[0], t[1], r.memread, t[2], t[4:0], t[7:5], t[1:0], t[6:4],
                r.u1, r.u2, {16'h0, t, 8'h00}, {4{t}}, {4{~t}}, {t, 24'h0},
                r.rs1, r.rs2, r.rd};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d actual %h required %h", nm, idx, act, exp);
        end
    endtask

    // Drive inputs just after a rising edge, check stall mid-cycle, then clock and check ex_*.
    task automatic run_row(input row_t r, input int idx, input logic [VW-1:0] exp_vec);
        rstn  = r.rstn;
        hold  = r.hold;
        flush = r.flush;
        {id_valid, id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc, id_ALUOp, id_NPCOp,
         id_WDSel, id_DMType, id_use_rs1, id_use_rs2, id_pc, id_rd1, id_rd2, id_imm,
         id_rs1, id_rs2, id_rd} = row_vec(r);
        if (!r.rstn) begin
            id_rd1 = $urandom;
            id_rd2 = $urandom;
        end
        #2;
        if (r.chk_stall) chk("stall", idx, {{(VW-1){1'b0}}, stall}, {{(VW-1){1'b0}}, r.exp_stall});
        @(posedge clk);
        #1;
        chk("ex_fields", idx, ex_vec, exp_vec);
    endtask

    initial begin
        row_t a, b, c;
        logic [VW-1:0] e;

        //        rstn hold flush  v mr rd rs1 rs2 u1 u2  tag  cs es src
        rows[0]  = mk(0, 0, 0,   1, 1,  5,  5, 0, 1, 0,   1,  0, 0, -1);
        rows[1]  = mk(0, 0, 0,   1, 0,  3,  1, 2, 1, 1,   2,  1, 0, -1);
        rows[2]  = mk(1, 0, 0,   1, 0,  3,  1, 2, 1, 1,   3,  1, 0,  2);
        rows[3]  = mk(1, 0, 0,   1, 1,  5,  1, 0, 1, 0,   4,  1, 0,  3);
        rows[4]  = mk(1, 0, 0,   1, 0,  6,  5, 2, 1, 1,   5,  1, 1, -1);
        rows[5]  = mk(1, 0, 0,   1, 0,  6,  5, 2, 1, 1,   5,  1, 0,  5);
        rows[6]  = mk(1, 0, 0,   1, 1,  0,  3, 0, 1, 0,   6,  1, 0,  6);
        rows[7]  = mk(1, 0, 0,   1, 0,  8,  0, 0, 1, 0,   7,  1, 0,  7);
        rows[8]  = mk(1, 0, 0,   1, 1,  7,  1, 0, 1, 0,   8,  1, 0,  8);
        rows[9]  = mk(1, 0, 0,   1, 0,  9,  2, 7, 1, 0,   9,  1, 0,  9);
        rows[10] = mk(1, 0, 0,   1, 1,  7,  1, 0, 1, 0,  10,  1, 0, 10);
        rows[11] = mk(1, 0, 1,   1, 0, 11,  3, 7, 1, 1,  11,  1, 0, -1);
        rows[12] = mk(1, 0, 0,   1, 1,  4,  1, 0, 1, 0,  12,  1, 0, 12);
        rows[13] = mk(1, 0, 0,   0, 0, 13,  4, 0, 1, 0,  13,  1, 0, 13);
        rows[14] = mk(1, 0, 0,   1, 0, 10,  1, 2, 1, 1,  14,  1, 0, 14);
        rows[15] = mk(1, 1, 1,   1, 0, 15,  1, 2, 1, 1,  15,  1, 0, 14);
        rows[16] = mk(1, 1, 1,   1, 1, 16,  3, 4, 1, 1,  16,  1, 0, 14);
        rows[17] = mk(1, 1, 1,   1, 0, 17, 10,10, 1, 1,  17,  1, 0, 14);
        rows[18] = mk(1, 0, 1,   1, 0, 18,  2, 3, 1, 1,  18,  1, 0, -1);
        rows[19] = mk(1, 0, 0,   1, 1,  9,  1, 0, 1, 0,  19,  1, 0, 19);
        rows[20] = mk(1, 1, 0,   1, 0, 20,  9, 0, 1, 0,  20,  1, 1, 19);
        rows[21] = mk(1, 0, 0,   1, 0, 20,  9, 0, 1, 0,  20,  1, 1, -1);
        rows[22] = mk(1, 0, 0,   1, 0, 20,  9, 0, 1, 0,  20,  1, 0, 22);
        rows[23] = mk(0, 1, 1,   1, 1, 23,  1, 1, 1, 1,  23,  1, 0, -1);
        rows[24] = mk(1, 0, 0,   1, 0, 24,  1, 2, 1, 1,  24,  1, 0, 24);

        @(posedge clk);
        #1;
        for (int i = 0; i < 25; i++) begin
            e = (rows[i].exp_src < 0) ? '0 : row_vec(rows[rows[i].exp_src]);
            run_row(rows[i], i, e);
        end

        // Load chain: lw x5; lw x6,0(x5); add x?,x6 -> one bubble per dependent load.
        a = mk(1, 0, 0, 1, 1, 5, 1, 0, 1, 0, 30, 1, 0, 0);
        b = mk(1, 0, 0, 1, 1, 6, 5, 0, 1, 0, 31, 1, 1, 0);
        c = mk(1, 0, 0, 1, 0, 12, 6, 0, 1, 0, 32, 1, 1, 0);
        run_row(a, 100, row_vec(a));
        run_row(b, 101, '0);
        b.exp_stall = 1'b0;
        run_row(b, 102, row_vec(b));
        run_row(c, 103, '0);
        c.exp_stall = 1'b0;
        run_row(c, 104, row_vec(c));

`ifdef ID_EX_PERF_CNT_EN
        begin
            row_t rz, ld, cf, cu;
            rz = mk(0, 0, 0, 1, 0, 1, 1, 1, 1, 1, 40, 1, 0, 0);
            ld = mk(1, 0, 0, 1, 1, 5, 1, 0, 1, 0, 41, 1, 0, 0);
            cf = mk(1, 0, 1, 1, 0, 9, 5, 0, 1, 0, 42, 1, 0, 0);
            cu = mk(1, 0, 0, 1, 0, 9, 5, 0, 1, 0, 43, 1, 1, 0);
            run_row(rz, 200, '0);
            chk("perf_lu_rst", 200, {131'd0, perf_lu_cnt}, '0);
            chk("perf_flush_rst", 200, {131'd0, perf_flush_cnt}, '0);
            run_row(ld, 201, row_vec(ld));
            run_row(cf, 202, '0);
            chk("perf_flush_vs_lu_f", 202, {131'd0, perf_flush_cnt}, VW'(1));
            chk("perf_flush_vs_lu_l", 202, {131'd0, perf_lu_cnt}, '0);
            run_row(ld, 203, row_vec(ld));
            run_row(cu, 204, '0);
            chk("perf_lu_inc", 204, {131'd0, perf_lu_cnt}, VW'(1));
            run_row(ld, 205, row_vec(ld));
            force dut.lu_cnt_q = 32'hFFFF_FFFF;
            #1;
            release dut.lu_cnt_q;
            run_row(cu, 206, '0);
            chk("perf_lu_wrap", 206, {131'd0, perf_lu_cnt}, '0);
            chk("perf_flush_keep", 206, {131'd0, perf_flush_cnt}, VW'(1));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register of the 5-stage RV32I pipeline, directly downstream of the instruction decoder.
- Captures decoder control outputs plus ID-stage operands each cycle.
- Detects load-use hazards and inserts bubbles; also applies branch/jump flush from EX.
- Optionally counts bubbles for performance analysis.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  synchronous active-low reset.
- hold  in  1  global freeze (e.g. memory wait); all state held.
- flush  in  1  EX-stage redirect (branch taken / jal / jalr); kills the instruction in ID.
- id_valid  in  1  ID slot holds a real instruction.
- id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc  in  1 each  decoder controls.
- id_ALUOp  in  5  decoder ALU op.
- id_NPCOp  in  3  decoder next-PC op.
- id_WDSel  in  2  decoder writeback select.
- id_DMType  in  3  decoder memory access type.
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1 / rs2.
- id_pc, id_rd1, id_rd2, id_imm  in  XLEN each  PC, register operands, extended immediate.
- id_rs1, id_rs2, id_rd  in  RA_W each  register addresses.
- ex_*  out  same widths  registered copies of every id_* field above (ex_valid included).
- stall  out  1  combinational; freezes PC and IF/ID when high.

Behaviour:
- Reset: when rstn==0 at a rising edge, all ex_* outputs become 0 (ex_valid=0). Reset overrides hold and flush. stall is combinational and reads 0 while the registers hold reset values.
- Load-use detect (combinational): lu = ex_valid & ex_MemRead & (ex_rd!=0) & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- stall = lu & ~flush.
- Update priority at each rising edge (rstn==1):
  1. hold=1: all ex_* keep their value. flush and lu are ignored; upstream keeps flush asserted until hold drops.
  2. flush=1: load a bubble.
  3. lu=1: load a bubble; ID keeps the instruction via stall, so it re-enters next cycle.
  4. Otherwise: load all id_* fields; ex_valid=id_valid.
- Bubble: every ex_* output, including datapath fields, is 0. ALUOp=0 is a no-op; NPCOp=0 is PC+4.
- Latency: 1 cycle ID to EX. A load-use pair costs exactly 1 bubble, because the second compare sees a bubble in EX (ex_MemRead=0).
- id_valid=0 loads as a bubble-equivalent: controls pass through unchanged, but downstream qualifies on ex_valid. When id_valid=0, lu is 0.
- Writes to x0 never cause a stall.
- No internal FSM beyond the valid bit. The counters below are the only multi-bit state besides the pipeline fields.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds two extra ports.
  - perf_lu_cnt  out  32
  - perf_flush_cnt  out  32
- Both reset to 0. Each increments on an edge where that bubble cause (lu or flush) was applied and hold=0. Both wrap 0xFFFFFFFF to 0.
- Undefined: the ports and counters do not exist. Pipeline behaviour is identical either way.

Test Plan:
- Reset: drive random id_*, rstn=0 for 2 edges -> all ex_*=0, stall=0; first edge after release loads id_* unchanged.
- Load-use: EX holds lw with rd=5 (MemRead=1); ID holds add rs1=5, use_rs1=1 -> stall=1 and a bubble enters EX. Next cycle add enters EX with rs1=5 and stall=0.
- x0 and unused-source cases: lw rd=0 followed by an rs1=0 consumer -> stall=0. lw rd=7 followed by addi rs2 field=7 with use_rs2=0 -> stall=0.
- Flush vs load-use: flush=1 in the same cycle as lu=1 -> stall=0, bubble loaded. With ID_EX_PERF_CNT_EN, perf_flush_cnt increments by 1 and perf_lu_cnt is unchanged.
- Hold: hold=1 for 3 cycles with flush=1 and changing id_* -> ex_* unchanged throughout. After release with flush still 1 -> bubble loaded.
- Counter wrap (ID_EX_PERF_CNT_EN): force perf_lu_cnt to 0xFFFFFFFF, apply one load-use -> value becomes 0x00000000.
